// File: rtl/ttl_serial_demux8_pkg.sv
// Shared constants for the serial demux block: mode encodings and default
// holding-register width.
package ttl_pkg;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_DIRECT = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ttl_serial_demux8_addr_latch.sv
// Clocked addressable latch (74259-style): one bit written per enabled edge,
// synchronous clear has priority over the write.
import ttl_pkg::*;

module addr_latch #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] addr,
  input  logic             din,
  input  logic             we,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q[addr] <= din;
    end
  end

endmodule

// File: rtl/ttl_serial_demux8.sv
// Serial-to-parallel demux: auto/direct bit addressing into a holding register,
// byte completion into a valid/ack output register with sticky overrun.
import ttl_pkg::*;

module ttl_serial_demux8 #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] S,
  input  logic             din,
  input  logic             wr,
  input  logic             clr,
  input  logic             q_ack,
  output logic [WIDTH-1:0] Out,
  output logic [SEL_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overrun
);

  logic [SEL_W-1:0] addr;
  logic             auto_wr;
  logic             complete;
  logic             accept;
  logic [WIDTH-1:0] done_byte;

  assign addr     = (mode == MODE_DIRECT) ? S : cnt;
  assign auto_wr  = wr & ~clr & (mode == MODE_AUTO);
  assign complete = auto_wr & (cnt == SEL_W'(WIDTH - 1));
  assign accept   = complete & (~q_valid | q_ack);
  // The last bit is still in flight into Out, so splice it in directly.
  assign done_byte = {din, Out[WIDTH-2:0]};

  addr_latch #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_out (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .din  (din),
    .we   (wr),
    .clr  (clr),
    .q    (Out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (auto_wr) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (accept) begin
      q       <= done_byte;
      q_valid <= 1'b1;
    end else if (q_ack) begin
      q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (complete && !accept) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ttl_serial_demux8.sv
// Bench for ttl_serial_demux8: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the holding/output registers.
module tb_ttl_serial_demux8;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [2:0] S;
  logic       din;
  logic       wr;
  logic       clr;
  logic       q_ack;
  logic [7:0] Out;
  logic [2:0] cnt;
  logic [7:0] q;
  logic       q_valid;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  ttl_serial_demux8 dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .S      (S),
    .din    (din),
    .wr     (wr),
    .clr    (clr),
    .q_ack  (q_ack),
    .Out    (Out),
    .cnt    (cnt),
    .q      (q),
    .q_valid(q_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: bits land at an integer address, a byte is the register
  // contents after the 8th auto write.
  logic [7:0] out_m;
  int         cnt_m;
  logic [7:0] q_m;
  logic       qv_m;
  logic       ov_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      out_m = 8'h00; cnt_m = 0; q_m = 8'h00; qv_m = 1'b0; ov_m = 1'b0;
    end else begin
      logic qv0;
      logic finished;
      qv0 = qv_m;
      finished = 1'b0;
      if (clr) begin
        out_m = 8'h00; cnt_m = 0; ov_m = 1'b0;
      end else if (wr) begin
        if (mode == 1'b0) begin
          out_m[cnt_m] = din;
          finished = (cnt_m == 7);
          cnt_m = (cnt_m + 1) % 8;
        end else begin
          out_m[S] = din;
        end
      end
      if (q_ack) qv_m = 1'b0;
      if (finished) begin
        if (!qv0 || q_ack) begin
          q_m = out_m;
          qv_m = 1'b1;
        end else begin
          ov_m = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("Out", {8'h00, Out}, {8'h00, out_m});
      chk("cnt", {13'h0, cnt}, 16'(cnt_m));
      chk("q", {8'h00, q}, {8'h00, q_m});
      chk("q_valid", {15'h0, q_valid}, {15'h0, qv_m});
      chk("overrun", {15'h0, overrun}, {15'h0, ov_m});
    end
  end

  task automatic cyc(input logic m, input logic [2:0] sel, input logic d,
                     input logic w, input logic c, input logic a);
    mode = m; S = sel; din = d; wr = w; clr = c; q_ack = a;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack();
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last_ack);
    for (int k = 0; k < 8; k++)
      cyc(1'b0, 3'd0, b[k], 1'b1, 1'b0, (k == 7) ? last_ack : 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    mode = 1'b0; S = 3'd0; din = 1'b0; wr = 1'b0; clr = 1'b0; q_ack = 1'b0;
    #3;
    chk("rst_Out", {8'h00, Out}, 16'h0000);
    chk("rst_cnt", {13'h0, cnt}, 16'h0000);
    chk("rst_q", {8'h00, q}, 16'h0000);
    chk("rst_qv", {15'h0, q_valid}, 16'h0000);
    chk("rst_ov", {15'h0, overrun}, 16'h0000);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // 1,0,1,1,0,0,1,0 -> 8'h4D
    send_byte(8'h4D, 1'b0);
    chk("b4d_q", {8'h00, q}, 16'h004D);
    chk("b4d_qv", {15'h0, q_valid}, 16'h0001);
    chk("b4d_cnt", {13'h0, cnt}, 16'h0000);
    ack();
    chk("ack_qv", {15'h0, q_valid}, 16'h0000);

    send_byte(8'hA5, 1'b0);
    chk("a5_q", {8'h00, q}, 16'h00A5);
    send_byte(8'h3C, 1'b1);
    chk("3c_q", {8'h00, q}, 16'h003C);
    chk("3c_qv", {15'h0, q_valid}, 16'h0001);
    chk("3c_ov", {15'h0, overrun}, 16'h0000);
    ack();

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("ovr_q", {8'h00, q}, 16'h0011);
    chk("ovr_ov", {15'h0, overrun}, 16'h0001);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ov", {15'h0, overrun}, 16'h0000);
    chk("clr_Out", {8'h00, Out}, 16'h0000);
    chk("clr_cnt", {13'h0, cnt}, 16'h0000);
    chk("clr_qv", {15'h0, q_valid}, 16'h0001);
    ack();

    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dir_out6", {15'h0, Out[6]}, 16'h0001);
    chk("dir_cnt", {13'h0, cnt}, 16'h0003);
    for (int k = 0; k < 5; k++) cyc(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mix_q", {8'h00, q}, 16'h0007);
    chk("mix_qv", {15'h0, q_valid}, 16'h0001);
    ack();

    for (int k = 0; k < 7; k++) cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_cnt7", {13'h0, cnt}, 16'h0007);
    cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cw_qv", {15'h0, q_valid}, 16'h0000);
    chk("cw_cnt", {13'h0, cnt}, 16'h0000);
    chk("cw_Out", {8'h00, Out}, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 3));
    end
    idle();
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    send_byte(8'h5A, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_cnt5", {13'h0, cnt}, 16'h0005);
    chk("mid_qv", {15'h0, q_valid}, 16'h0001);
    wr = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_Out", {8'h00, Out}, 16'h0000);
    chk("arst_cnt", {13'h0, cnt}, 16'h0000);
    chk("arst_q", {8'h00, q}, 16'h0000);
    chk("arst_qv", {15'h0, q_valid}, 16'h0000);
    chk("arst_ov", {15'h0, overrun}, 16'h0000);
    @(negedge clk);
    #1;
    reset = 1'b0;
    send_byte(8'h96, 1'b0);
    chk("post_q", {8'h00, q}, 16'h0096);
    chk("post_qv", {15'h0, q_valid}, 16'h0001);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl_serial_demux8.md
# ttl_serial_demux8

Serial-to-parallel demultiplexer with addressable holding register: the receive-side counterpart of the 8:1 data selector used for parallel-to-serial transfer on the CPU's narrow buses. Each accepted bit lands in the holding-register position given by an internal 3-bit address counter (auto mode) or by an external select (direct mode). Completed bytes are handed downstream through a valid/ack handshake. `cnt` is exported so the upstream selector's `S` input can be driven from the same sequence.

## Interface
Parameters:
- `WIDTH`, 8: holding-register width; a power of 2 in the range 2..16.
- `SEL_W`, $clog2(WIDTH): select/counter width; derived, not overridden.

Ports (clock is `clk`; reset is `reset`, asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `mode`  in  1  0 = auto (address from `cnt`), 1 = direct (address from `S`)
- `S`  in  SEL_W  direct-mode bit address
- `din`  in  1  data bit
- `wr`  in  1  write strobe; a bit is accepted on every rising edge with `wr`=1
- `clr`  in  1  synchronous clear of `Out`, `cnt` and `overrun`
- `q_ack`  in  1  downstream accepts `q`
- `Out`  out  WIDTH  holding register, bit k = last bit written to address k
- `cnt`  out  SEL_W  auto-mode address of the next bit
- `q`  out  WIDTH  completed byte
- `q_valid`  out  1  `q` holds an unconsumed byte
- `overrun`  out  1  sticky; a completed byte was dropped

## Operation
- Reset (asynchronous): `Out`=0, `cnt`=0, `q`=0, `q_valid`=0, `overrun`=0.
- Edge priority: `clr` first, then `wr`.
- `clr`=1: sets `Out`=0, `cnt`=0 and `overrun`=0. The write is ignored. `q` and `q_valid` are unaffected, and `q_ack` is still honoured.
- Auto write (`mode`=0, `wr`=1):
  - `Out[cnt]` takes `din`.
  - `cnt` increments modulo WIDTH (7 wraps to 0).
- Byte completion: an auto write with `cnt`=WIDTH-1. On that edge:
  - If `q_valid`=0, or `q_ack`=1 on the same edge: `q` takes `Out` with bit WIDTH-1 replaced by `din`, and `q_valid`=1.
  - Otherwise: `q` is unchanged, the byte is dropped, and `overrun`=1.
  - In both cases `Out` is updated normally.
- Direct write (`mode`=1, `wr`=1):
  - `Out[S]` takes `din`.
  - `cnt` does not change and the write never completes a byte.
  - This mode behaves as a clocked 74259-style addressable latch.
- Handshake: `q_ack`=1 while `q_valid`=1 sets `q_valid`=0, unless a completion on the same edge reloads it. `q_ack` while `q_valid`=0 is ignored.
- Mode change mid-byte: `cnt` and `Out` are retained, so the auto sequence resumes where it stopped.
- `wr`=0: `Out` and `cnt` hold.
- Logical states (encoded by `cnt` and `q_valid`): FILLING(cnt), FULL. FULL+FILLING coexist because the holding register and output register are independent.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Write latency: `Out` reflects an accepted bit 1 cycle after the strobing edge.
- Completion latency: `q`/`q_valid` valid 1 cycle after the 8th auto write. Sustained 1 bit/clk gives 1 byte every WIDTH clocks with no bubbles.
- `q` is stable whenever `q_valid`=1 until the ack edge.
- Reset asserted mid-byte: immediate return to reset values, no partial byte delivered. The first bit after deassertion goes to address 0.

## Structure
- Shared package `ttl_pkg`:
  - `MODE_AUTO`=1'b0 and `MODE_DIRECT`=1'b1
  - default `WIDTH`
- Sub-module `addr_latch`: WIDTH-bit clocked addressable latch (inputs: address, `din`, write enable, clear; output: the register). It is instantiated once for `Out`.
- The top level holds the counter, completion/overrun logic and output register.

## Test plan
- Reset, then auto write of 1,0,1,1,0,0,1,0 on consecutive clocks -> `q`=8'h4D, `q_valid`=1 one cycle after the 8th edge, `cnt`=0.
- Two back-to-back bytes 8'hA5, 8'h3C with `q_ack` pulsed on the second completion edge -> `q`=8'h3C, `q_valid` stays 1, `overrun`=0.
- Two bytes with no `q_ack` -> `q` keeps the first byte, `overrun`=1. Then `clr` -> `overrun`=0, `Out`=0, `cnt`=0, `q_valid` still 1.
- After 3 auto bits, switch to direct and write `din`=1 at `S`=6 -> `Out[6]`=1 and `cnt`=3. Return to auto, 5 more bits -> byte completes, with `Out` bit 6 overwritten by the auto sequence.
- `clr` and `wr` on the same edge with `cnt`=7 -> no completion, `cnt`=0, `Out`=0.
- Assert `reset` asynchronously mid-byte (`cnt`=5, `q_valid`=1) -> all outputs 0 before the next edge. 8 fresh bits then produce a correct byte.
